// File: rtl/seq_divider_pkg.sv
// ---------------------------------------------------------------------------
// seq_divider_pkg : shared datapath width and divider FSM state encoding
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package seq_divider_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_ITER = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } div_state_t;

endpackage

`default_nettype wire

// File: rtl/seq_divider_cond_negate.sv
// ---------------------------------------------------------------------------
// cond_negate : two's-complement negate when enabled, pass-through otherwise
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cond_negate #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] data_o
);

    assign data_o = en_i ? (~data_i + WIDTH'(1)) : data_i;

endmodule

`default_nettype wire

// File: rtl/seq_divider.sv
// ---------------------------------------------------------------------------
// seq_divider : multi-cycle signed/unsigned restoring divider (LO=quotient, HI=remainder)
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    div_state_t       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] bmag_q, bmag_d;
    logic [WIDTH-1:0] qw_q, qw_d;
    logic [WIDTH-1:0] rw_q, rw_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sgn_q, sgn_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             busy_q, busy_d;
    logic             dbz_q, dbz_d;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag, q_fix, r_fix;
    logic [WIDTH:0]   r_shift;
    logic [WIDTH-1:0] r_sub;
    logic             fits;

    assign a_neg = sgn_q & a_q[WIDTH-1];
    assign b_neg = sgn_q & b_q[WIDTH-1];

    cond_negate #(.WIDTH(WIDTH)) u_neg_a (.data_i(a_q),  .en_i(a_neg),  .data_o(a_mag));
    cond_negate #(.WIDTH(WIDTH)) u_neg_b (.data_i(b_q),  .en_i(b_neg),  .data_o(b_mag));
    cond_negate #(.WIDTH(WIDTH)) u_neg_q (.data_i(qw_q), .en_i(qneg_q), .data_o(q_fix));
    cond_negate #(.WIDTH(WIDTH)) u_neg_r (.data_i(rw_q), .en_i(rneg_q), .data_o(r_fix));

    // The shifted partial remainder carries one extra bit so the compare
    // against the divisor magnitude can never overflow.
    assign r_shift = {rw_q, qw_q[WIDTH-1]};
    assign fits    = (r_shift >= {1'b0, bmag_q});
    assign r_sub   = r_shift[WIDTH-1:0] - bmag_q;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        bmag_d  = bmag_q;
        qw_d    = qw_q;
        rw_d    = rw_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        sgn_d   = sgn_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        busy_d  = busy_q;
        dbz_d   = dbz_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = dividend;
                    b_d     = divisor;
                    sgn_d   = signed_op;
                    busy_d  = 1'b1;
                    state_d = S_PREP;
                end
            end
            S_PREP: begin
                bmag_d  = b_mag;
                qw_d    = a_mag;
                rw_d    = '0;
                qneg_d  = a_neg ^ b_neg;
                rneg_d  = a_neg;
                cnt_d   = CNT_LAST;
                state_d = S_ITER;
            end
            S_ITER: begin
                if (fits) begin
                    rw_d = r_sub;
                    qw_d = {qw_q[WIDTH-2:0], 1'b1};
                end else begin
                    rw_d = r_shift[WIDTH-1:0];
                    qw_d = {qw_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                // A zero divisor still runs the full iteration so latency stays fixed.
                if (b_q == '0) begin
                    quo_d = '1;
                    rem_d = a_q;
                    dbz_d = 1'b1;
                end else begin
                    quo_d = q_fix;
                    rem_d = r_fix;
                    dbz_d = 1'b0;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            bmag_q  <= '0;
            qw_q    <= '0;
            rw_q    <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            sgn_q   <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            busy_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            bmag_q  <= bmag_d;
            qw_q    <= qw_d;
            rw_q    <= rw_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            sgn_q   <= sgn_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            busy_q  <= busy_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = (state_q == S_DONE);
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_divider.sv
// ---------------------------------------------------------------------------
// tb_seq_divider : directed self-checking bench for seq_divider
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_seq_divider;

    logic        clk = 1'b0;
    logic        clr;
    logic        start;
    logic        signed_op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seq_divider dut (
        .clk        (clk),
        .clr        (clr),
        .start      (start),
        .signed_op  (signed_op),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents operands with start high across one accepting edge.
    task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s);
        dividend  = a;
        divisor   = b;
        signed_op = s;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    // Follows one operation from the accepting edge: busy without done for 33
    // edges, old results held, done sampled by the 35th edge, then idle.
    task automatic wait_result(input string tag, input logic [31:0] eq, input logic [31:0] er,
                               input logic edbz, input logic [31:0] hold_q,
                               input int pulse_at, input bit start_in_done);
        logic busy_ok = 1'b1;
        logic hold_ok = 1'b1;
        for (int k = 1; k <= 33; k++) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b1) busy_ok = 1'b0;
            if (quotient !== hold_q) hold_ok = 1'b0;
            if (k == pulse_at) begin
                start    = 1'b1;
                dividend = 32'd1000;
                divisor  = 32'd3;
            end else begin
                start = 1'b0;
            end
        end
        chk({tag, "_busy_no_early_done"}, {31'b0, busy_ok}, 32'd1);
        chk({tag, "_outputs_held"},       {31'b0, hold_ok}, 32'd1);
        tick();
        chk({tag, "_done"},      {31'b0, done}, 32'd1);
        chk({tag, "_quotient"},  quotient, eq);
        chk({tag, "_remainder"}, remainder, er);
        chk({tag, "_dbz"},       {31'b0, div_by_zero}, {31'b0, edbz});
        if (start_in_done) start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_done_pulse_ends"}, {31'b0, done}, 32'd0);
        chk({tag, "_idle_after"},      {31'b0, busy}, 32'd0);
    endtask

    initial begin
        logic no_done;
        clr       = 1'b1;
        start     = 1'b0;
        signed_op = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_q",    quotient, 32'd0);
        chk("rst_r",    remainder, 32'd0);
        chk("rst_dbz",  {31'b0, div_by_zero}, 32'd0);
        clr = 1'b0;
        tick();

        launch(32'd100, 32'd7, 1'b0);
        wait_result("u100_7", 32'd14, 32'd2, 1'b0, 32'd0, 0, 1'b0);

        launch(32'hFFFF_FF9C, 32'd7, 1'b1);
        wait_result("s_m100_7", 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 32'd14, 0, 1'b0);

        launch(32'd100, 32'hFFFF_FFF9, 1'b1);
        wait_result("s_100_m7", 32'hFFFF_FFF2, 32'd2, 1'b0, 32'hFFFF_FFF2, 0, 1'b0);

        launch(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        wait_result("s_ovf", 32'h8000_0000, 32'd0, 1'b0, 32'hFFFF_FFF2, 0, 1'b0);

        launch(32'hFFFF_FFFF, 32'd2, 1'b0);
        wait_result("u_max_2", 32'h7FFF_FFFF, 32'd1, 1'b0, 32'h8000_0000, 0, 1'b0);

        launch(32'h1234_5678, 32'd0, 1'b0);
        wait_result("u_dbz", 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 32'h7FFF_FFFF, 0, 1'b1);

        launch(32'hFFFF_FFFB, 32'd0, 1'b1);
        wait_result("s_dbz", 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, 32'hFFFF_FFFF, 0, 1'b0);

        launch(32'd50, 32'd6, 1'b0);
        wait_result("repulse", 32'd8, 32'd2, 1'b0, 32'hFFFF_FFFF, 5, 1'b0);

        launch(32'd100, 32'd7, 1'b0);
        repeat (9) tick();
        clr = 1'b1;
        #1;
        chk("clr_busy", {31'b0, busy}, 32'd0);
        chk("clr_done", {31'b0, done}, 32'd0);
        chk("clr_q",    quotient, 32'd0);
        chk("clr_r",    remainder, 32'd0);
        chk("clr_dbz",  {31'b0, div_by_zero}, 32'd0);
        repeat (2) tick();
        clr = 1'b0;
        no_done = 1'b1;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b0) no_done = 1'b0;
        end
        chk("clr_no_done", {31'b0, no_done}, 32'd1);

        launch(32'hFFFF_FFF9, 32'd2, 1'b1);
        wait_result("after_clr", 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 32'd0, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
